// File: rtl/vga_fb_reader_if.sv
// Frame buffer read port and video output bundle of the VGA frame buffer reader.
// The master side is the reader; the slave side is the BRAM plus the downstream RGB stage.
interface vga_fb_reader_if #(
    parameter int ADDR_W = 17
);
    logic [ADDR_W-1:0] fb_addr;
    logic              fb_rd_en;
    logic [11:0]       fb_data;
    logic [11:0]       data;
    logic              nBlank;
    logic              hsync;
    logic              vsync;
    logic              frame_start;

    modport master (
        output fb_addr, fb_rd_en, data, nBlank, hsync, vsync, frame_start,
        input  fb_data
    );

    modport slave (
        input  fb_addr, fb_rd_en, data, nBlank, hsync, vsync, frame_start,
        output fb_data
    );
endinterface

// File: rtl/vga_fb_reader.sv
// VGA raster timing generator that fetches an upscaled frame from BRAM (RGB444) and
// presents pixel data, nBlank, hsync and vsync aligned two pixel ticks after the counters.
module vga_fb_reader #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int SCALE_SHIFT = 1,
    parameter int ADDR_W      = 17,
    parameter bit SYNC_POL    = 1'b0
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            pix_en,
    vga_fb_reader_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);

    localparam logic [H_W-1:0]    H_ZERO    = H_W'(0);
    localparam logic [H_W-1:0]    H_ONE     = H_W'(1);
    localparam logic [H_W-1:0]    H_LAST    = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0]    H_ACT     = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0]    HS_BEG    = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0]    HS_END    = H_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [V_W-1:0]    V_ZERO    = V_W'(0);
    localparam logic [V_W-1:0]    V_ONE     = V_W'(1);
    localparam logic [V_W-1:0]    V_LAST    = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0]    V_ACT     = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0]    VS_BEG    = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0]    VS_END    = V_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    // Low row bits all ones marks the last display line sharing a stored line (always true at 1:1).
    localparam logic [V_W-1:0]    V_MASK    = V_W'((1 << SCALE_SHIFT) - 1);
    localparam logic [ADDR_W-1:0] A_ZERO    = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE >> SCALE_SHIFT);

    logic [H_W-1:0]    h_r;
    logic [V_W-1:0]    v_r;
    logic [ADDR_W-1:0] line_base_r;

    logic              active_s;
    logic              hs_s;
    logic              vs_s;
    logic              origin_s;
    logic [ADDR_W-1:0] addr_s;

    logic              b_active_r;
    logic              b_hs_r;
    logic              b_vs_r;
    logic              b_origin_r;
    logic [ADDR_W-1:0] fb_addr_r;
    logic              fb_rd_en_r;

    logic [11:0]       data_r;
    logic              nblank_r;
    logic              hsync_r;
    logic              vsync_r;
    logic              frame_start_r;

    // Stage A decode of the current raster position.
    always_comb begin
        active_s = (h_r < H_ACT) && (v_r < V_ACT);
        hs_s     = (h_r >= HS_BEG) && (h_r <= HS_END);
        vs_s     = (v_r >= VS_BEG) && (v_r <= VS_END);
        origin_s = (h_r == H_ZERO) && (v_r == V_ZERO);
        addr_s   = line_base_r + ADDR_W'(h_r >> SCALE_SHIFT);
    end

    // Stage A raster counters and the running base address of the stored line.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            h_r         <= H_ZERO;
            v_r         <= V_ZERO;
            line_base_r <= A_ZERO;
        end else if (pix_en) begin
            if (h_r == H_LAST) begin
                h_r <= H_ZERO;
                if (v_r == V_LAST) begin
                    v_r         <= V_ZERO;
                    line_base_r <= A_ZERO;
                end else begin
                    v_r <= v_r + V_ONE;
                    if ((v_r < V_ACT) && ((v_r & V_MASK) == V_MASK)) begin
                        line_base_r <= line_base_r + LINE_STEP;
                    end else begin
                        line_base_r <= line_base_r;
                    end
                end
            end else begin
                h_r <= h_r + H_ONE;
            end
        end else begin
            h_r         <= h_r;
            v_r         <= v_r;
            line_base_r <= line_base_r;
        end
    end

    // Stage B launches the BRAM read; the address is held outside the active area.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fb_addr_r  <= A_ZERO;
            fb_rd_en_r <= 1'b0;
            b_active_r <= 1'b0;
            b_hs_r     <= 1'b0;
            b_vs_r     <= 1'b0;
            b_origin_r <= 1'b0;
        end else begin
            fb_rd_en_r <= pix_en & active_s;
            if (pix_en) begin
                if (active_s) begin
                    fb_addr_r <= addr_s;
                end else begin
                    fb_addr_r <= fb_addr_r;
                end
                b_active_r <= active_s;
                b_hs_r     <= hs_s;
                b_vs_r     <= vs_s;
                b_origin_r <= origin_s;
            end else begin
                fb_addr_r  <= fb_addr_r;
                b_active_r <= b_active_r;
                b_hs_r     <= b_hs_r;
                b_vs_r     <= b_vs_r;
                b_origin_r <= b_origin_r;
            end
        end
    end

    // Stage C registers the pixel and its sync/blank flags together so they stay aligned.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_r        <= 12'h000;
            nblank_r      <= 1'b0;
            hsync_r       <= ~SYNC_POL;
            vsync_r       <= ~SYNC_POL;
            frame_start_r <= 1'b0;
        end else begin
            frame_start_r <= pix_en & b_origin_r;
            if (pix_en) begin
                data_r   <= b_active_r ? bus.fb_data : 12'h000;
                nblank_r <= b_active_r;
                hsync_r  <= b_hs_r ? SYNC_POL : ~SYNC_POL;
                vsync_r  <= b_vs_r ? SYNC_POL : ~SYNC_POL;
            end else begin
                data_r   <= data_r;
                nblank_r <= nblank_r;
                hsync_r  <= hsync_r;
                vsync_r  <= vsync_r;
            end
        end
    end

    assign bus.fb_addr     = fb_addr_r;
    assign bus.fb_rd_en    = fb_rd_en_r;
    assign bus.data        = data_r;
    assign bus.nBlank      = nblank_r;
    assign bus.hsync       = hsync_r;
    assign bus.vsync       = vsync_r;
    assign bus.frame_start = frame_start_r;
endmodule

// File: tb/tb_vga_fb_reader.sv
// Bench for vga_fb_reader: a default-timing instance checked against a hand-built vector table,
// and a shrunken-timing instance checked tick by tick against a raster model under random pix_en.
module tb_vga_fb_reader;
    typedef struct { int ha, hf, hs, hb, va, vf, vs, vb, sh; } cfg_t;
    typedef struct { int data; int nb; int hs; int vs; int fs; } vid_t;
    typedef struct { int tick; int data; int nb; int hs; int vs; int fs; } vec_t;

    cfg_t CS = '{16, 2, 3, 3, 8, 2, 2, 2, 1};

    logic clk = 1'b0;
    logic resetn;
    logic pe_d;
    logic pe_s;

    always #5 clk = ~clk;

    vga_fb_reader_if #(.ADDR_W(17)) bus_d ();
    vga_fb_reader_if #(.ADDR_W(6))  bus_s ();

    vga_fb_reader dut_d (
        .clk    (clk),
        .resetn (resetn),
        .pix_en (pe_d),
        .bus    (bus_d)
    );

    vga_fb_reader #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8),  .V_FP(2), .V_SYNC(2), .V_BP(2),
        .SCALE_SHIFT(1), .ADDR_W(6), .SYNC_POL(1'b0)
    ) dut_s (
        .clk    (clk),
        .resetn (resetn),
        .pix_en (pe_s),
        .bus    (bus_s)
    );

    // BRAM stand-ins: the reader's fb_addr/fb_rd_en registers act as the BRAM input register,
    // so the word for a read appears one clk after the read is launched and holds between reads.
    always_latch begin
        if (bus_d.fb_rd_en) bus_d.fb_data <= bus_d.fb_addr[11:0];
    end
    always_latch begin
        if (bus_s.fb_rd_en) bus_s.fb_data <= bus_s.fb_addr[11:0];
    end

    int n_run  = 0;
    int n_fail = 0;
    int tick_s = 0;
    int max_addr = -1;
    bit count_reads = 1'b0;
    int reads [64];
    int fs_ticks [$];

    task automatic chk(input string name, input int act, input int exp);
        n_run++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int htot(cfg_t c); return c.ha + c.hf + c.hs + c.hb; endfunction
    function automatic int vtot(cfg_t c); return c.va + c.vf + c.vs + c.vb; endfunction

    function automatic bit pix_active(cfg_t c, int idx);
        int h, v;
        if (idx < 0) return 1'b0;
        h = idx % htot(c);
        v = (idx / htot(c)) % vtot(c);
        return (h < c.ha) && (v < c.va);
    endfunction

    function automatic int pix_addr(cfg_t c, int idx);
        int h, v;
        h = idx % htot(c);
        v = (idx / htot(c)) % vtot(c);
        return (v >> c.sh) * (c.ha >> c.sh) + (h >> c.sh);
    endfunction

    // Expected video outputs for raster position idx (pixels counted from (0,0)); negative = pre-roll.
    function automatic vid_t model(cfg_t c, int idx);
        vid_t r;
        int h, v;
        r = '{0, 0, 1, 1, 0};
        if (idx >= 0) begin
            h = idx % htot(c);
            v = (idx / htot(c)) % vtot(c);
            r.nb   = pix_active(c, idx) ? 1 : 0;
            r.data = pix_active(c, idx) ? (pix_addr(c, idx) % 4096) : 0;
            r.hs   = (h >= c.ha + c.hf && h < c.ha + c.hf + c.hs) ? 0 : 1;
            r.vs   = (v >= c.va + c.vf && v < c.va + c.vf + c.vs) ? 0 : 1;
            r.fs   = (h == 0 && v == 0) ? 1 : 0;
        end
        return r;
    endfunction

    function automatic vid_t obs_d();
        vid_t r;
        r.data = int'(bus_d.data);
        r.nb   = int'(bus_d.nBlank);
        r.hs   = int'(bus_d.hsync);
        r.vs   = int'(bus_d.vsync);
        r.fs   = int'(bus_d.frame_start);
        return r;
    endfunction

    function automatic vid_t obs_s();
        vid_t r;
        r.data = int'(bus_s.data);
        r.nb   = int'(bus_s.nBlank);
        r.hs   = int'(bus_s.hsync);
        r.vs   = int'(bus_s.vsync);
        r.fs   = int'(bus_s.frame_start);
        return r;
    endfunction

    task automatic chk_vid(input string tag, input vid_t o, input vid_t e);
        chk({tag, ".data"},   o.data, e.data);
        chk({tag, ".nBlank"}, o.nb,   e.nb);
        chk({tag, ".hsync"},  o.hs,   e.hs);
        chk({tag, ".vsync"},  o.vs,   e.vs);
        chk({tag, ".fs"},     o.fs,   e.fs);
    endtask

    // One clk of the small instance with full output, read-enable and address checks.
    task automatic small_clk(input bit pe);
        vid_t e;
        int a;
        pe_s = pe;
        @(posedge clk);
        #1;
        if (pe) tick_s++;
        e = model(CS, tick_s - 2);
        if (!pe) e.fs = 0;
        chk_vid("s", obs_s(), e);
        chk("s.fb_rd_en", int'(bus_s.fb_rd_en), (pe && pix_active(CS, tick_s - 1)) ? 1 : 0);
        if (bus_s.fb_rd_en) begin
            a = int'(bus_s.fb_addr);
            if (pe) chk("s.fb_addr", a, pix_addr(CS, tick_s - 1));
            if (a > max_addr) max_addr = a;
            if (count_reads && (tick_s - 1) < htot(CS) * vtot(CS)) reads[a]++;
        end
        if (pe && bus_s.frame_start) fs_ticks.push_back(tick_s);
    endtask

    initial begin
        vec_t tbl [13];
        vid_t o;
        int nb_cnt, hs_cnt, hs_first, prev_nb, rise0, rise1, guard;

        tbl[0]  = '{1,    0,   0, 1, 1, 0};
        tbl[1]  = '{2,    0,   1, 1, 1, 1};
        tbl[2]  = '{3,    0,   1, 1, 1, 0};
        tbl[3]  = '{4,    1,   1, 1, 1, 0};
        tbl[4]  = '{641,  319, 1, 1, 1, 0};
        tbl[5]  = '{642,  0,   0, 1, 1, 0};
        tbl[6]  = '{657,  0,   0, 1, 1, 0};
        tbl[7]  = '{658,  0,   0, 0, 1, 0};
        tbl[8]  = '{753,  0,   0, 0, 1, 0};
        tbl[9]  = '{754,  0,   0, 1, 1, 0};
        tbl[10] = '{802,  0,   1, 1, 1, 0};
        tbl[11] = '{1602, 320, 1, 1, 1, 0};
        tbl[12] = '{1605, 321, 1, 1, 1, 0};
        foreach (reads[i]) reads[i] = 0;

        resetn = 1'b0;
        pe_d   = 1'b0;
        pe_s   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_vid("rst_d", obs_d(), '{0, 0, 1, 1, 0});
        chk_vid("rst_s", obs_s(), '{0, 0, 1, 1, 0});
        chk("rst_d.fb_rd_en", int'(bus_d.fb_rd_en), 0);
        chk("rst_d.fb_addr",  int'(bus_d.fb_addr),  0);
        resetn = 1'b1;

        // Default 640x480 timing, pix_en every clk, spot-checked from the vector table.
        nb_cnt = 0; hs_cnt = 0; hs_first = -1; prev_nb = 0; rise0 = -1; rise1 = -1;
        pe_d = 1'b1;
        for (int t = 1; t <= 1700; t++) begin
            @(posedge clk);
            #1;
            o = obs_d();
            if (t == 1) begin
                chk("d.fb_rd_en_t1", int'(bus_d.fb_rd_en), 1);
                chk("d.fb_addr_t1",  int'(bus_d.fb_addr),  0);
            end
            for (int k = 0; k < 13; k++) begin
                if (tbl[k].tick == t)
                    chk_vid($sformatf("d.t%0d", t), o, '{tbl[k].data, tbl[k].nb, tbl[k].hs, tbl[k].vs, tbl[k].fs});
            end
            if (t >= 2 && t <= 801) begin
                nb_cnt += o.nb;
                if (o.hs == 0) begin
                    hs_cnt++;
                    if (hs_first < 0) hs_first = t - 2;
                end
            end
            if (o.nb == 1 && prev_nb == 0) begin
                if (rise0 < 0) rise0 = t;
                else if (rise1 < 0) rise1 = t;
            end
            prev_nb = o.nb;
        end
        pe_d = 1'b0;
        chk("d.nblank_per_line", nb_cnt, 640);
        chk("d.hsync_low_clks", hs_cnt, 96);
        chk("d.hsync_start_h", hs_first, 656);
        chk("d.line_period", rise1 - rise0, 800);
        chk_vid("s.held_in_reset_state", obs_s(), '{0, 0, 1, 1, 0});

        // Small instance: random pix_en over more than two frames, read counts over frame 0.
        count_reads = 1'b1;
        guard = 0;
        while (tick_s < 2 * htot(CS) * vtot(CS) + 60 && guard < 5000) begin
            small_clk($urandom_range(0, 3) != 0);
            guard++;
        end
        chk("s.random_budget", (guard < 5000) ? 1 : 0, 1);
        count_reads = 1'b0;
        for (int a = 0; a < 32; a++) chk($sformatf("s.reads[%0d]", a), reads[a], 4);
        chk("s.max_addr", max_addr, 31);
        chk("s.frame_starts", (fs_ticks.size() >= 2) ? 1 : 0, 1);
        if (fs_ticks.size() >= 2) chk("s.frame_period", fs_ticks[1] - fs_ticks[0], htot(CS) * vtot(CS));

        // Every 4th clk: same sequence at quarter rate, outputs held and rd_en one clk wide.
        for (int n = 0; n < 400; n++) small_clk(n % 4 == 0);

        // Mid-frame reset at (h=10, v=5): immediate reset values, then frame_start two ticks after release.
        guard = 0;
        while ((tick_s % (htot(CS) * vtot(CS))) != 5 * htot(CS) + 10 && guard < 1000) begin
            small_clk(1'b1);
            guard++;
        end
        chk("s.seek_budget", (guard < 1000) ? 1 : 0, 1);
        pe_s = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        chk_vid("s.midreset", obs_s(), '{0, 0, 1, 1, 0});
        chk("s.midreset.fb_rd_en", int'(bus_s.fb_rd_en), 0);
        chk("s.midreset.fb_addr",  int'(bus_s.fb_addr),  0);
        chk_vid("d.midreset", obs_d(), '{0, 0, 1, 1, 0});
        @(posedge clk);
        #1;
        resetn = 1'b1;
        tick_s = 0;
        small_clk(1'b1);
        chk("s.fs_tick1", int'(bus_s.frame_start), 0);
        small_clk(1'b1);
        chk("s.fs_tick2", int'(bus_s.frame_start), 1);
        for (int n = 0; n < 200; n++) small_clk($urandom_range(0, 1) == 1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
